// File: rtl/bp_cce_resource_arbiter.sv
// N-requester arbiter for one CCE shared resource: fixed-priority class over round-robin, lock, stall gating.
// Optional starvation counters enabled by defining BP_CCE_ARB_STARVE_EN.
module bp_cce_resource_arbiter #(
    parameter int                   num_req_p       = 3,
    parameter int                   payload_width_p = 64,
    parameter logic [num_req_p-1:0] hipri_mask_p    = 'b001,
    parameter logic [num_req_p-1:0] stall_mask_p    = 'b010,
    parameter int                   starve_limit_p  = 8,
    localparam int                  id_width_lp     = (num_req_p > 1) ? $clog2(num_req_p) : 1
) (
    input  logic                                 clk_i,
    input  logic                                 reset_n_i,
    input  logic                                 stall_i,
    input  logic [num_req_p-1:0]                 req_v_i,
    input  logic [num_req_p-1:0]                 req_lock_i,
    input  logic [num_req_p*payload_width_p-1:0] req_data_i,
    output logic [num_req_p-1:0]                 req_ready_o,
    output logic                                 v_o,
    output logic [payload_width_p-1:0]           data_o,
    output logic [id_width_lp-1:0]               grant_id_o,
    input  logic                                 ready_i,
    output logic                                 locked_o
);

    typedef enum logic {e_idle, e_locked} lock_state_e;

    lock_state_e            state_r, state_n;
    logic [id_width_lp-1:0] lock_id_r;
    logic [id_width_lp-1:0] rr_ptr_r;
    logic [num_req_p-1:0]   eligible;
    logic                   gnt_found;
    logic [id_width_lp-1:0] gnt_id;
    logic                   xfer;

    assign eligible = req_v_i & ~(stall_mask_p & {num_req_p{stall_i}});

`ifdef BP_CCE_ARB_STARVE_EN
    localparam int cnt_width_lp = $clog2(starve_limit_p + 1);
    logic [cnt_width_lp-1:0] starve_cnt_r [num_req_p];
`else
    logic unused_starve_limit;
    assign unused_starve_limit = (starve_limit_p != 0);
`endif

    always_comb begin
        gnt_found = 1'b0;
        gnt_id    = '0;
        if (state_r == e_locked) begin
            // A held lock blocks everyone else, even when the owner is not asking.
            if (eligible[lock_id_r]) begin
                gnt_found = 1'b1;
                gnt_id    = lock_id_r;
            end
        end else begin
`ifdef BP_CCE_ARB_STARVE_EN
            for (int i = 0; i < num_req_p; i++) begin
                if (!gnt_found && eligible[i] && (starve_cnt_r[i] == cnt_width_lp'(starve_limit_p))) begin
                    gnt_found = 1'b1;
                    gnt_id    = id_width_lp'(i);
                end
            end
`endif
            for (int i = 0; i < num_req_p; i++) begin
                if (!gnt_found && eligible[i] && hipri_mask_p[i]) begin
                    gnt_found = 1'b1;
                    gnt_id    = id_width_lp'(i);
                end
            end
            // Round-robin in two passes: from the pointer upward, then wrap to index 0.
            for (int i = 0; i < num_req_p; i++) begin
                if (!gnt_found && eligible[i] && !hipri_mask_p[i] && (id_width_lp'(i) >= rr_ptr_r)) begin
                    gnt_found = 1'b1;
                    gnt_id    = id_width_lp'(i);
                end
            end
            for (int i = 0; i < num_req_p; i++) begin
                if (!gnt_found && eligible[i] && !hipri_mask_p[i]) begin
                    gnt_found = 1'b1;
                    gnt_id    = id_width_lp'(i);
                end
            end
        end
    end

    assign v_o        = reset_n_i & gnt_found;
    assign xfer       = v_o & ready_i;
    assign grant_id_o = v_o ? gnt_id : '0;
    assign data_o     = v_o ? req_data_i[gnt_id*payload_width_p +: payload_width_p] : '0;
    assign locked_o   = (state_r == e_locked);

    always_comb begin
        req_ready_o = '0;
        for (int i = 0; i < num_req_p; i++) begin
            req_ready_o[i] = xfer && (gnt_id == id_width_lp'(i));
        end
    end

    always_comb begin
        state_n = state_r;
        case (state_r)
            e_idle:   if (xfer && req_lock_i[gnt_id])  state_n = e_locked;
            e_locked: if (xfer && !req_lock_i[gnt_id]) state_n = e_idle;
            default:  state_n = e_idle;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r   <= e_idle;
            lock_id_r <= '0;
            rr_ptr_r  <= '0;
        end else begin
            state_r <= state_n;
            if (xfer && req_lock_i[gnt_id]) begin
                lock_id_r <= gnt_id;
            end
            if (xfer && !hipri_mask_p[gnt_id]) begin
                rr_ptr_r <= (gnt_id == id_width_lp'(num_req_p - 1)) ? '0 : gnt_id + 1'b1;
            end
        end
    end

`ifdef BP_CCE_ARB_STARVE_EN
    // A stalled requester keeps its accumulated wait; dropping valid forfeits it.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < num_req_p; i++) starve_cnt_r[i] <= '0;
        end else begin
            for (int i = 0; i < num_req_p; i++) begin
                if (xfer && (gnt_id == id_width_lp'(i))) begin
                    starve_cnt_r[i] <= '0;
                end else if (eligible[i]) begin
                    if (starve_cnt_r[i] != cnt_width_lp'(starve_limit_p))
                        starve_cnt_r[i] <= starve_cnt_r[i] + 1'b1;
                end else if (!(req_v_i[i] && stall_mask_p[i] && stall_i)) begin
                    starve_cnt_r[i] <= '0;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_bp_cce_resource_arbiter.sv
// Directed bench for bp_cce_resource_arbiter: a rule-level model checked every cycle plus literal expectations.
module tb_bp_cce_resource_arbiter;

    localparam int N = 3;
    localparam int W = 64;
    localparam int LIMIT = 8;
    localparam logic [N-1:0] HIPRI = 3'b001;
    localparam logic [N-1:0] STALLM = 3'b010;

    logic           clk = 1'b0;
    logic           reset_n;
    logic           stall;
    logic [N-1:0]   req_v;
    logic [N-1:0]   req_lock;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           v_o;
    logic [W-1:0]   data_o;
    logic [1:0]     grant_id;
    logic           ready;
    logic           locked;

    logic [W-1:0] pay [N];

    int n_vec = 0;
    int n_err = 0;

    int m_rr, m_lock, m_lock_id;
    int m_cnt [N];

    always #5 clk = ~clk;

    assign req_data = {pay[2], pay[1], pay[0]};

    bp_cce_resource_arbiter #(
        .num_req_p(N), .payload_width_p(W), .hipri_mask_p(HIPRI),
        .stall_mask_p(STALLM), .starve_limit_p(LIMIT)
    ) dut (
        .clk_i(clk), .reset_n_i(reset_n), .stall_i(stall), .req_v_i(req_v),
        .req_lock_i(req_lock), .req_data_i(req_data), .req_ready_o(req_ready),
        .v_o(v_o), .data_o(data_o), .grant_id_o(grant_id), .ready_i(ready),
        .locked_o(locked)
    );

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit elig(int i);
        return req_v[i] && !(STALLM[i] && stall);
    endfunction

    // Winner by the precedence rules; -1 means no grant.
    function automatic int model_grant();
        if (m_lock != 0) return elig(m_lock_id) ? m_lock_id : -1;
`ifdef BP_CCE_ARB_STARVE_EN
        for (int i = 0; i < N; i++) if (elig(i) && m_cnt[i] == LIMIT) return i;
`endif
        for (int i = 0; i < N; i++) if (elig(i) && HIPRI[i]) return i;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (m_rr + k) % N;
            if (elig(idx) && !HIPRI[idx]) return idx;
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        if (!reset_n) begin
            check("rst_v", {63'b0, v_o}, 0);
            check("rst_ready", {61'b0, req_ready}, 0);
            check("rst_gid", {62'b0, grant_id}, 0);
            check("rst_data", data_o, 0);
            check("rst_locked", {63'b0, locked}, 0);
            m_rr = 0; m_lock = 0; m_lock_id = 0;
            for (int i = 0; i < N; i++) m_cnt[i] = 0;
        end else begin
            int g;
            bit xf;
            g  = model_grant();
            xf = (g >= 0) && ready;
            check("v_o", {63'b0, v_o}, (g >= 0) ? 1 : 0);
            check("grant_id", {62'b0, grant_id}, (g >= 0) ? g : 0);
            check("data_o", data_o, (g >= 0) ? pay[g] : '0);
            check("req_ready", {61'b0, req_ready}, xf ? (64'd1 << g) : 0);
            check("locked", {63'b0, locked}, m_lock);
            for (int i = 0; i < N; i++) begin
                if (xf && g == i) m_cnt[i] = 0;
                else if (elig(i)) m_cnt[i] = (m_cnt[i] < LIMIT) ? m_cnt[i] + 1 : LIMIT;
                else if (!(req_v[i] && STALLM[i] && stall)) m_cnt[i] = 0;
            end
            if (xf) begin
                if (!HIPRI[g]) m_rr = (g + 1) % N;
                if (req_lock[g]) begin
                    m_lock = 1; m_lock_id = g;
                end else if (m_lock != 0) begin
                    m_lock = 0;
                end
            end
        end
    end

    task automatic drive(input logic [N-1:0] v, input logic [N-1:0] lk, input logic st, input logic rdy);
        req_v = v; req_lock = lk; stall = st; ready = rdy;
        #2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        pay[0] = 64'h0000_0000_AAAA_0000;
        pay[1] = 64'h1111_0000_0000_1111;
        pay[2] = 64'h2222_2222_0000_0000;
        reset_n = 1'b0;

        // Reset: everything requesting, nothing granted
        drive(3'b111, 3'b000, 1'b0, 1'b1);
        check("t1_v_in_reset", {63'b0, v_o}, 0);
        check("t1_ready_in_reset", {61'b0, req_ready}, 0);
        tick(); tick();
        reset_n = 1'b1;
        drive(3'b111, 3'b000, 1'b0, 1'b1);
        check("t1_gid_after_reset", {62'b0, grant_id}, 0);
        tick();

        // Round-robin among 1 and 2
        for (int c = 0; c < 4; c++) begin
            drive(3'b110, 3'b000, 1'b0, 1'b1);
            check("t2_rr_gid", {62'b0, grant_id}, (c % 2 == 0) ? 1 : 2);
            tick();
        end

        // Stall gating of requester 1
        drive(3'b010, 3'b000, 1'b1, 1'b1);
        check("t3_stalled_v", {63'b0, v_o}, 0);
        tick();
        drive(3'b010, 3'b000, 1'b0, 1'b1);
        check("t3_unstall_gid", {62'b0, grant_id}, 1);
        check("t3_unstall_ready", {61'b0, req_ready}, 3'b010);
        tick();

        // Lock by requester 2 blocks hipri requester 0
        drive(3'b100, 3'b100, 1'b0, 1'b1);
        check("t4_lock_gid", {62'b0, grant_id}, 2);
        tick();
        for (int c = 0; c < 3; c++) begin
            drive(3'b101, 3'b100, 1'b0, 1'b1);
            check("t4_held_gid", {62'b0, grant_id}, 2);
            check("t4_held_locked", {63'b0, locked}, 1);
            tick();
        end
        drive(3'b101, 3'b000, 1'b0, 1'b1);
        check("t4_unlock_gid", {62'b0, grant_id}, 2);
        tick();
        drive(3'b001, 3'b000, 1'b0, 1'b1);
        check("t4_after_gid", {62'b0, grant_id}, 0);
        check("t4_after_locked", {63'b0, locked}, 0);
        tick();

        // Backpressure: held grant, stable data, pointer untouched
        pay[0] = 64'hDEAD_BEEF_0123_4567;
        for (int c = 0; c < 5; c++) begin
            drive(3'b001, 3'b000, 1'b0, 1'b0);
            check("t5_bp_v", {63'b0, v_o}, 1);
            check("t5_bp_data", data_o, 64'hDEAD_BEEF_0123_4567);
            check("t5_bp_ready", {61'b0, req_ready}, 0);
            tick();
        end
        drive(3'b110, 3'b000, 1'b0, 1'b1);
        check("t5_rr_kept", {62'b0, grant_id}, 1);
        tick();

        // Grant moves when the current winner drops valid before transfer
        drive(3'b110, 3'b000, 1'b0, 1'b0);
        check("drop_first_gid", {62'b0, grant_id}, 2);
        tick();
        drive(3'b010, 3'b000, 1'b0, 1'b0);
        check("drop_moved_gid", {62'b0, grant_id}, 1);
        tick();

        // Lock owner stalled: nobody else may win
        drive(3'b010, 3'b010, 1'b0, 1'b1);
        check("stlock_gid", {62'b0, grant_id}, 1);
        tick();
        drive(3'b011, 3'b000, 1'b1, 1'b1);
        check("stlock_v", {63'b0, v_o}, 0);
        check("stlock_locked", {63'b0, locked}, 1);
        tick();
        drive(3'b011, 3'b000, 1'b0, 1'b1);
        check("stlock_owner_gid", {62'b0, grant_id}, 1);
        tick();
        drive(3'b011, 3'b000, 1'b0, 1'b1);
        check("stlock_release_gid", {62'b0, grant_id}, 0);
        tick();

        // Reset in the middle of a lock
        drive(3'b100, 3'b100, 1'b0, 1'b1);
        tick();
        drive(3'b000, 3'b000, 1'b0, 1'b1);
        check("midrst_locked_before", {63'b0, locked}, 1);
        reset_n = 1'b0;
        #1;
        check("midrst_locked_now", {63'b0, locked}, 0);
        tick();
        reset_n = 1'b1;
        drive(3'b111, 3'b000, 1'b0, 1'b1);
        check("midrst_gid", {62'b0, grant_id}, 0);
        tick();

`ifdef BP_CCE_ARB_STARVE_EN
        // Starvation: requester 1 wins on its ninth waiting cycle
        reset_n = 1'b0;
        drive(3'b000, 3'b000, 1'b0, 1'b1);
        tick();
        reset_n = 1'b1;
        for (int c = 0; c < 9; c++) begin
            drive(3'b011, 3'b000, 1'b0, 1'b1);
            check("t6_starve_gid", {62'b0, grant_id}, (c < 8) ? 0 : 1);
            tick();
        end
        drive(3'b000, 3'b000, 1'b0, 1'b1);
        check("t6_cnt_cleared", 64'(dut.starve_cnt_r[1]), 0);
        tick();
`endif

        drive(3'b000, 3'b000, 1'b0, 1'b1);
        tick(); tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
